// File: rtl/gpc_pkg.sv
// Shared widths and types for the weighted-popcount (2,2,3:4) arbiter slice.
package gpc_pkg;

    localparam int NREQ  = 2;
    localparam int SRC0W = 3;
    localparam int SRC1W = 2;
    localparam int SRC2W = 2;
    localparam int SUMW  = 4;

    // Requester identity; also used for the round-robin pointer.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_sel_e;

endpackage

// File: rtl/gpc223_4_arbiter_if.sv
// Requester/consumer bundle of the shared gpc223_4 arbiter.
interface gpc223_4_arbiter_if
    import gpc_pkg::*;
#(
    parameter int CNTW = 8
) ();

    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [SRC0W-1:0] req_src0 [NREQ];
    logic [SRC1W-1:0] req_src1 [NREQ];
    logic [SRC2W-1:0] req_src2 [NREQ];
    logic             out_valid;
    logic             out_ready;
    logic [SUMW-1:0]  out_sum;
    logic             out_id;
    logic [CNTW-1:0]  served_cnt [NREQ];

    // Environment side: requesters and result consumer.
    modport master (
        output req_valid, req_src0, req_src1, req_src2, out_ready,
        input  req_ready, out_valid, out_sum, out_id, served_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_src0, req_src1, req_src2, out_ready,
        output req_ready, out_valid, out_sum, out_id, served_cnt
    );

endinterface

// File: rtl/gpc223_4.sv
// Generalized parallel counter: popcount(src0) + 2*popcount(src1) + 4*popcount(src2).
module gpc223_4
    import gpc_pkg::*;
(
    input  logic [SRC0W-1:0] src0,
    input  logic [SRC1W-1:0] src1,
    input  logic [SRC2W-1:0] src2,
    output logic [SUMW-1:0]  sum
);

    logic [1:0] cnt0;
    logic [1:0] cnt1;
    logic [1:0] cnt2;

    // Per-weight popcounts, then shift-align and add.
    always_comb begin
        cnt0 = {1'b0, src0[0]} + {1'b0, src0[1]} + {1'b0, src0[2]};
        cnt1 = {1'b0, src1[0]} + {1'b0, src1[1]};
        cnt2 = {1'b0, src2[0]} + {1'b0, src2[1]};
        sum  = {2'b00, cnt0} + {1'b0, cnt1, 1'b0} + {cnt2, 2'b00};
    end

endmodule

// File: rtl/gpc223_4_arbiter.sv
// Two requesters share one gpc223_4 through a round-robin grant and a
// single-entry result register with full-throughput drain-and-accept.
module gpc223_4_arbiter
    import gpc_pkg::*;
#(
    parameter int CNTW = 8
) (
    input logic               clk,
    input logic               rst,
    gpc223_4_arbiter_if.slave bus
);

    logic             slot_free;
    logic             grant_vld;
    req_sel_e         grant;
    req_sel_e         rr;
    logic [SRC0W-1:0] mux_src0;
    logic [SRC1W-1:0] mux_src1;
    logic [SRC2W-1:0] mux_src2;
    logic [SUMW-1:0]  gpc_sum;
    logic             out_valid_q;
    logic [SUMW-1:0]  out_sum_q;
    req_sel_e         out_id_q;
    logic [CNTW-1:0]  cnt_q [NREQ];

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // Grant: sole valid requester wins, rr breaks ties; never while reset or slot busy.
    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        if (bus.req_valid[0] && bus.req_valid[1]) begin
            grant = rr;
        end else begin
            grant = bus.req_valid[1] ? REQ1 : REQ0;
        end
        grant_vld = !rst && slot_free && (|bus.req_valid);
        bus.req_ready        = '0;
        bus.req_ready[grant] = grant_vld;
    end

    // Operand mux into the shared counter; the loser's sources never reach it.
    always_comb begin
        mux_src0 = bus.req_src0[grant];
        mux_src1 = bus.req_src1[grant];
        mux_src2 = bus.req_src2[grant];
    end

    gpc223_4 u_gpc (
        .src0 (mux_src0),
        .src1 (mux_src1),
        .src2 (mux_src2),
        .sum  (gpc_sum)
    );

    // Result register, round-robin pointer and saturating served counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_id_q    <= REQ0;
            rr          <= REQ0;
            for (int r = 0; r < NREQ; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (grant_vld) begin
            out_valid_q  <= 1'b1;
            out_sum_q    <= gpc_sum;
            out_id_q     <= grant;
            rr           <= (grant == REQ0) ? REQ1 : REQ0;
            cnt_q[grant] <= sat_inc(cnt_q[grant]);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Registered state onto the bus.
    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_sum   = out_sum_q;
        bus.out_id    = out_id_q;
        for (int r = 0; r < NREQ; r++) begin
            bus.served_cnt[r] = cnt_q[r];
        end
    end

endmodule

// File: tb/tb_gpc223_4_arbiter.sv
// Bench for gpc223_4_arbiter: vector table plus hand sequences, results
// checked through a scoreboard queue.
module tb_gpc223_4_arbiter;
    import gpc_pkg::*;

    localparam int CNTW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpc223_4_arbiter_if #(.CNTW(CNTW)) bus ();

    gpc223_4_arbiter #(.CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // a0/a1 pack {src2, src1, src0} for requester 0/1.
    typedef struct {
        logic       r;
        logic [1:0] v;
        logic [6:0] a0;
        logic [6:0] a1;
        logic       ordy;
        logic [1:0] rdy;
        logic [3:0] sum;
    } vec_t;

    typedef struct {
        logic [3:0] sum;
        logic       id;
    } res_t;

    vec_t tbl[$];
    res_t sb[$];
    int   cnt_m[2];
    bit   clean;
    int   n_vec;
    int   n_err;

    localparam logic [6:0] P29 = 7'b00_01_111; // src0=7 src1=1 src2=0 -> 5
    localparam logic [6:0] PA  = 7'b10_11_011; // src0=3 src1=3 src2=2 -> 10
    localparam logic [6:0] PB  = 7'b01_01_001; // src0=1 src1=1 src2=1 -> 7

    function automatic logic [3:0] wsum(input logic [6:0] a);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++) s += int'(a[i]);
        for (int i = 3; i < 5; i++) s += 2 * int'(a[i]);
        for (int i = 5; i < 7; i++) s += 4 * int'(a[i]);
        return 4'(s);
    endfunction

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [6:0] a0,
                                input logic [6:0] a1, input logic ordy, input logic [1:0] rdy,
                                input logic [3:0] sum);
        vec_t t;
        t.r = r; t.v = v; t.a0 = a0; t.a1 = a1; t.ordy = ordy; t.rdy = rdy; t.sum = sum;
        return t;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at vector %0d: got %0d, expected %0d", nm, n_vec, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        int id;
        rst           = t.r;
        bus.req_valid = t.v;
        bus.req_src0[0] = t.a0[2:0]; bus.req_src1[0] = t.a0[4:3]; bus.req_src2[0] = t.a0[6:5];
        bus.req_src0[1] = t.a1[2:0]; bus.req_src1[1] = t.a1[4:3]; bus.req_src2[1] = t.a1[6:5];
        bus.out_ready = t.ordy;
        #1;
        n_vec++;
        check("req_ready", int'(bus.req_ready), int'(t.rdy));
        check("out_valid", int'(bus.out_valid), int'(sb.size() > 0));
        if (sb.size() > 0) begin
            check("out_sum", int'(bus.out_sum), int'(sb[0].sum));
            check("out_id", int'(bus.out_id), int'(sb[0].id));
        end else if (clean) begin
            check("out_sum_reset", int'(bus.out_sum), 0);
            check("out_id_reset", int'(bus.out_id), 0);
        end
        check("served_cnt0", int'(bus.served_cnt[0]), cnt_m[0]);
        check("served_cnt1", int'(bus.served_cnt[1]), cnt_m[1]);
        @(posedge clk);
        if (t.r) begin
            sb.delete();
            cnt_m[0] = 0;
            cnt_m[1] = 0;
            clean = 1'b1;
        end else begin
            if (sb.size() > 0 && t.ordy) void'(sb.pop_front());
            if (t.rdy != 2'b00) begin
                id = int'(t.rdy[1]);
                sb.push_back('{sum: t.sum, id: t.rdy[1]});
                if (cnt_m[id] < (1 << CNTW) - 1) cnt_m[id]++;
                clean = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        clean = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            bus.req_src0[r] = '0; bus.req_src1[r] = '0; bus.req_src2[r] = '0;
        end
        @(negedge clk);

        // Reset, single requester, idle-side isolation, contention.
        tbl.push_back(mk(1, 2'b00, 7'd0, 7'd0, 0, 2'b00, 4'd0));
        tbl.push_back(mk(1, 2'b11, PA,   PB,   1, 2'b00, 4'd0));
        tbl.push_back(mk(0, 2'b01, P29,  PB,   1, 2'b01, 4'd5));
        tbl.push_back(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));
        tbl.push_back(mk(0, 2'b10, 7'h7F, P29, 1, 2'b10, 4'd5));
        tbl.push_back(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));
        tbl.push_back(mk(1, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));
        tbl.push_back(mk(0, 2'b11, PA,   PB,   1, 2'b01, 4'hA));
        tbl.push_back(mk(0, 2'b11, PA,   PB,   1, 2'b10, 4'h7));
        tbl.push_back(mk(0, 2'b11, PA,   PB,   1, 2'b01, 4'hA));
        tbl.push_back(mk(0, 2'b11, PA,   PB,   1, 2'b10, 4'h7));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Backpressure: accept, hold three cycles, then drain and accept together.
        apply(mk(0, 2'b11, PA, PB, 1, 2'b01, 4'hA));
        for (int i = 0; i < 3; i++) apply(mk(0, 2'b11, PA, PB, 0, 2'b00, 4'd0));
        apply(mk(0, 2'b11, PA, PB, 1, 2'b10, 4'h7));
        apply(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));

        // Counter saturation with CNTW=2: five accepts of requester 0.
        apply(mk(1, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));
        for (int i = 0; i < 5; i++) apply(mk(0, 2'b01, PA, PB, 1, 2'b01, 4'hA));
        apply(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));

        // Reset with a held result and rr pointing at requester 1.
        apply(mk(0, 2'b01, PA, PB, 0, 2'b01, 4'hA));
        apply(mk(1, 2'b11, PA, PB, 0, 2'b00, 4'd0));
        apply(mk(0, 2'b11, PA, PB, 1, 2'b01, 4'hA));
        apply(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));

        // All 128 source patterns through requester 1, requester 0 idle with junk.
        for (int k = 0; k < 128; k++) begin
            apply(mk(0, 2'b10, 7'($urandom), 7'(k), 1, 2'b10, wsum(7'(k))));
        end
        apply(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));
        apply(mk(0, 2'b00, 7'd0, 7'd0, 1, 2'b00, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
